// File: rtl/piezo_pkg.sv
// Shared piezo definitions: note half-periods at 1 MHz, arbiter state encoding,
// sound-source indices and small arbitration helpers.
package piezo_pkg;

    localparam int NUM_SRC = 3;

    localparam logic [1:0] SRC_ALARM = 2'd0;
    localparam logic [1:0] SRC_CHIME = 2'd1;
    localparam logic [1:0] SRC_BEEP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_PLAY = 2'd2
    } arb_state_e;

    // Half-periods in clk1mhz cycles: L = C4 octave, M = C5, H = C6, HH1 = C7, HHH1 = C8.
    localparam logic [11:0] L1 = 12'd1911, L1S = 12'd1804, L2 = 12'd1703, L2S = 12'd1607;
    localparam logic [11:0] L3 = 12'd1517, L4  = 12'd1432, L4S = 12'd1351, L5 = 12'd1276;
    localparam logic [11:0] L5S = 12'd1204, L6 = 12'd1136, L6S = 12'd1073, L7 = 12'd1012;
    localparam logic [11:0] M1 = 12'd956, M1S = 12'd902, M2 = 12'd851, M2S = 12'd804;
    localparam logic [11:0] M3 = 12'd758, M4  = 12'd716, M4S = 12'd676, M5 = 12'd638;
    localparam logic [11:0] M5S = 12'd602, M6 = 12'd568, M6S = 12'd536, M7 = 12'd506;
    localparam logic [11:0] H1 = 12'd478, H1S = 12'd451, H2 = 12'd426, H2S = 12'd402;
    localparam logic [11:0] H3 = 12'd379, H4  = 12'd358, H4S = 12'd338, H5 = 12'd319;
    localparam logic [11:0] H5S = 12'd301, H6 = 12'd284, H6S = 12'd268, H7 = 12'd253;
    localparam logic [11:0] HH1 = 12'd239, HHH1 = 12'd119;

    // Lowest set index wins; callers only use it with a non-zero request vector.
    function automatic logic [1:0] lowest_idx(input logic [NUM_SRC-1:0] r);
        if (r[0]) return SRC_ALARM;
        if (r[1]) return SRC_CHIME;
        return SRC_BEEP;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Sources that outrank the given owner.
    function automatic logic [NUM_SRC-1:0] higher_mask(input logic [1:0] idx);
        return (3'b001 << idx) - 3'b001;
    endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: toggles every 'half' cycles while running and gated;
// clearing on gate low makes every note start phase-aligned.
module piezo_tone_gen #(
    parameter int HW = 12
) (
    input  logic          clk1mhz,
    input  logic          reset,
    input  logic          run,
    input  logic          gate,
    input  logic [HW-1:0] half,
    output logic          wave
);

    logic [HW-1:0] tcnt_q, tcnt_d;
    logic          tbuf_q, tbuf_d;

    // The >= compare lets a shortened half-period take effect immediately.
    always_comb begin
        tcnt_d = tcnt_q;
        tbuf_d = tbuf_q;
        if (!run || !gate || half == '0) begin
            tcnt_d = '0;
            tbuf_d = 1'b0;
        end else if (tcnt_q >= half - HW'(1)) begin
            tcnt_d = '0;
            tbuf_d = ~tbuf_q;
        end else begin
            tcnt_d = tcnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk1mhz or negedge reset) begin
        if (!reset) begin
            tcnt_q <= '0;
            tbuf_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tbuf_q <= tbuf_d;
        end
    end

    assign wave = tbuf_q;

endmodule

// File: rtl/piezo_arbiter.sv
// Shares the single piezo among alarm, chime and beep sources: fixed priority,
// silence gap on every ownership change, square wave from the owner's half-period.
module piezo_arbiter
    import piezo_pkg::*;
#(
    parameter int unsigned GAP_CYC = 2000,
    parameter bit          PREEMPT = 1'b1,
    parameter int          HW      = 12
) (
    input  logic               clk1mhz,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_SRC-1:0] req,
    input  logic [HW-1:0]      half0,
    input  logic [HW-1:0]      half1,
    input  logic [HW-1:0]      half2,
    input  logic [NUM_SRC-1:0] tone_on,
    output logic [NUM_SRC-1:0] gnt,
    output logic               busy,
    output logic               piezoout
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    arb_state_e         state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic [15:0]        gap_q, gap_d;

    logic [1:0]    pick;
    logic          preempt_hit;
    logic [HW-1:0] half_sel;
    logic          tone_gate;

    assign pick        = lowest_idx(req);
    assign preempt_hit = PREEMPT && ((req & higher_mask(owner_q)) != '0);

    // Release is tested before preemption so a simultaneous release always wins.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        gap_d   = gap_q;
        if (!enable) begin
            state_d = ST_IDLE;
            owner_d = SRC_ALARM;
            gnt_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req != '0) begin
                        state_d = ST_GAP;
                        owner_d = pick;
                        gnt_d   = onehot(pick);
                        gap_d   = '0;
                    end
                end
                ST_GAP, ST_PLAY: begin
                    if (!req[owner_q]) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        gap_d   = '0;
                    end else if (preempt_hit) begin
                        state_d = ST_GAP;
                        owner_d = pick;
                        gnt_d   = onehot(pick);
                        gap_d   = '0;
                    end else if (state_q == ST_GAP) begin
                        if (gap_q == GAP_LAST) begin
                            state_d = ST_PLAY;
                            gap_d   = '0;
                        end else begin
                            gap_d = gap_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    gap_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk1mhz or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= SRC_ALARM;
            gnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        case (owner_q)
            SRC_ALARM: half_sel = half0;
            SRC_CHIME: half_sel = half1;
            default:   half_sel = half2;
        endcase
    end

    // Gating on the next state silences the wave on the same edge that leaves PLAY.
    assign tone_gate = tone_on[owner_q] && (state_d == ST_PLAY);

    piezo_tone_gen #(
        .HW(HW)
    ) u_tone (
        .clk1mhz (clk1mhz),
        .reset   (reset),
        .run     (state_q == ST_PLAY),
        .gate    (tone_gate),
        .half    (half_sel),
        .wave    (piezoout)
    );

    assign gnt  = gnt_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piezo_arbiter.sv
// Bench for piezo_arbiter: preempting and non-preempting instances share one
// stimulus stream and are compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_piezo_arbiter;

    localparam int HW  = 12;
    localparam int GAP = 4;

    logic          clk1mhz = 1'b0;
    logic          reset;
    logic          enable;
    logic [2:0]    req;
    logic [HW-1:0] half0, half1, half2;
    logic [2:0]    tone_on;
    logic [2:0]    gnt_p, gnt_n;
    logic          busy_p, busy_n, pz_p, pz_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Model per instance (0 = preempting, 1 = non-preempting):
    // owner (-1 none), silent gap cycles left, cycles into current half, output level.
    int m_own[2];
    int m_gap[2];
    int m_cnt[2];
    bit m_lvl[2];

    always #500 clk1mhz = ~clk1mhz;

    piezo_arbiter #(.GAP_CYC(GAP), .PREEMPT(1'b1), .HW(HW)) dut_p (
        .clk1mhz(clk1mhz), .reset(reset), .enable(enable), .req(req),
        .half0(half0), .half1(half1), .half2(half2), .tone_on(tone_on),
        .gnt(gnt_p), .busy(busy_p), .piezoout(pz_p)
    );

    piezo_arbiter #(.GAP_CYC(GAP), .PREEMPT(1'b0), .HW(HW)) dut_n (
        .clk1mhz(clk1mhz), .reset(reset), .enable(enable), .req(req),
        .half0(half0), .half1(half1), .half2(half2), .tone_on(tone_on),
        .gnt(gnt_n), .busy(busy_n), .piezoout(pz_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_req(input logic [2:0] r);
        for (int i = 0; i < 3; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic int half_of(input int i);
        case (i)
            0:       return int'(half0);
            1:       return int'(half1);
            default: return int'(half2);
        endcase
    endfunction

    function automatic logic [2:0] exp_gnt(input int k);
        logic [2:0] one;
        one = 3'b001;
        if (m_own[k] < 0) return 3'b000;
        return one << m_own[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_gap[k] = 0; m_cnt[k] = 0; m_lvl[k] = 1'b0;
        end
    endtask

    task automatic new_owner(input int k, input int who);
        m_own[k] = who; m_gap[k] = GAP; m_cnt[k] = 0; m_lvl[k] = 1'b0;
    endtask

    task automatic drop_owner(input int k);
        m_own[k] = -1; m_gap[k] = 0; m_cnt[k] = 0; m_lvl[k] = 1'b0;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs seen at that edge.
    task automatic model_edge(input int k, input bit can_preempt);
        int top;
        int h;
        top = first_req(req);
        if (!enable) drop_owner(k);
        else if (m_own[k] < 0) begin
            if (top >= 0) new_owner(k, top);
        end else if (!req[m_own[k]]) drop_owner(k);
        else if (can_preempt && top < m_own[k]) new_owner(k, top);
        else if (m_gap[k] > 0) m_gap[k]--;
        else begin
            h = half_of(m_own[k]);
            if (h == 0 || !tone_on[m_own[k]]) begin
                m_cnt[k] = 0; m_lvl[k] = 1'b0;
            end else begin
                m_cnt[k]++;
                if (m_cnt[k] >= h) begin
                    m_cnt[k] = 0; m_lvl[k] = !m_lvl[k];
                end
            end
        end
    endtask

    task automatic compare_model();
        check("p.gnt",   32'(gnt_p),  32'(exp_gnt(0)));
        check("p.busy",  32'(busy_p), 32'(m_own[0] >= 0));
        check("p.piezo", 32'(pz_p),   32'(m_lvl[0]));
        check("n.gnt",   32'(gnt_n),  32'(exp_gnt(1)));
        check("n.busy",  32'(busy_n), 32'(m_own[1] >= 0));
        check("n.piezo", 32'(pz_n),   32'(m_lvl[1]));
    endtask

    task automatic step();
        @(posedge clk1mhz);
        model_edge(0, 1'b1);
        model_edge(1, 1'b0);
        #1;
        compare_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int idx;
        reset = 1'b0; enable = 1'b0; req = 3'b000; tone_on = 3'b000;
        half0 = '0; half1 = '0; half2 = '0;
        model_reset();
        #10;
        check("rst.gnt", 32'(gnt_p), 32'd0);
        check("rst.busy", 32'(busy_p), 32'd0);
        check("rst.piezo", 32'(pz_p), 32'd0);
        #100 reset = 1'b1;

        // Single request from the beep source.
        enable = 1'b1; half2 = 12'd10; tone_on = 3'b111; req = 3'b100;
        step();
        check("single.gnt", 32'(gnt_p), 32'b100);
        check("single.busy", 32'(busy_p), 32'd1);
        steps(13);
        check("single.silent", 32'(pz_p), 32'd0);
        step();
        check("single.rise", 32'(pz_p), 32'd1);
        steps(10);
        check("single.fall", 32'(pz_p), 32'd0);
        req = 3'b000;
        step();
        check("single.rel_gnt", 32'(gnt_p), 32'd0);
        check("single.rel_busy", 32'(busy_p), 32'd0);

        // Simultaneous requests: chime first, beep only after an idle cycle.
        req = 3'b110;
        step();
        check("simul.gnt", 32'(gnt_p), 32'b010);
        check("simul.gnt_np", 32'(gnt_n), 32'b010);
        steps(8);
        req = 3'b100;
        step();
        check("simul.rel", 32'(gnt_p), 32'd0);
        step();
        check("simul.next", 32'(gnt_p), 32'b100);

        // Alarm preempts the beep on the preempting instance only.
        steps(20);
        half0 = 12'd5; req = 3'b101;
        step();
        check("pre.gnt", 32'(gnt_p), 32'b001);
        check("pre.gnt_np", 32'(gnt_n), 32'b100);
        steps(8);
        check("pre.silent", 32'(pz_p), 32'd0);
        step();
        check("pre.rise", 32'(pz_p), 32'd1);
        check("pre.np_hold", 32'(gnt_n), 32'b100);
        req = 3'b000;
        steps(2);

        // Rest restarts the phase; shortened half-period applies at once.
        half1 = 12'd20; req = 3'b010;
        steps(30);
        tone_on = 3'b101;
        steps(7);
        check("rest.silent", 32'(pz_p), 32'd0);
        tone_on = 3'b111;
        steps(19);
        check("rest.aligned", 32'(pz_p), 32'd0);
        step();
        check("rest.rise", 32'(pz_p), 32'd1);
        steps(15);
        half1 = 12'd6;
        step();
        check("half.fast", 32'(pz_p), 32'd0);
        steps(5);
        check("half.hold", 32'(pz_p), 32'd0);
        step();
        check("half.period", 32'(pz_p), 32'd1);

        // Mute mid-play, then regrant.
        enable = 1'b0;
        step();
        check("mute.gnt", 32'(gnt_p), 32'd0);
        check("mute.busy", 32'(busy_p), 32'd0);
        check("mute.piezo", 32'(pz_p), 32'd0);
        enable = 1'b1;
        step();
        check("mute.regrant", 32'(gnt_p), 32'b010);

        // Asynchronous reset in the gap, away from any clock edge.
        steps(2);
        #100 reset = 1'b0;
        #1;
        check("areset.gnt", 32'(gnt_p), 32'd0);
        check("areset.busy", 32'(busy_p), 32'd0);
        check("areset.busy_np", 32'(busy_n), 32'd0);
        model_reset();
        #100 reset = 1'b1;

        // Zero half-period keeps the owner silent but granted.
        half1 = 12'd0;
        steps(35);
        check("zero.piezo", 32'(pz_p), 32'd0);
        check("zero.gnt", 32'(gnt_p), 32'b010);

        // Release coinciding with a higher-priority request: release wins.
        half1 = 12'd7;
        req = 3'b001;
        step();
        check("relwin.idle", 32'(gnt_p), 32'd0);
        step();
        check("relwin.next", 32'(gnt_p), 32'b001);
        req = 3'b000;
        step();

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) begin
                idx = int'($urandom_range(2));
                req[idx] = ~req[idx];
            end
            if ($urandom_range(20) == 0) begin
                idx = int'($urandom_range(2));
                tone_on[idx] = ~tone_on[idx];
            end
            if ($urandom_range(31) == 0) half0 = HW'($urandom_range(9));
            if ($urandom_range(31) == 0) half1 = HW'($urandom_range(9));
            if ($urandom_range(31) == 0) half2 = HW'($urandom_range(9));
            enable = ($urandom_range(99) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
